mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared 4 KB memory data port. It sits between the CPU load/store unit (requester 0) and a second master (requester 1: loader/debug/block-copy), and drives the memory's data address, write data, write enable and double-read/double-write controls. Each access is sequenced through a fixed three-state handshake. Read data is registered and returned with a one-cycle acknowledge. Requesters are granted round-robin.

---
 rtl/memarb_pkg.sv | 21 ++
 rtl/rr_pick2.sv | 29 ++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memarb_pkg.sv
// rtl/memarb_pkg.sv - shared widths, FSM state and request latch type for mem_arbiter
package memarb_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int ID_W   = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic              dbl;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin picker with optional lock owner
module rr_pick2
  import memarb_pkg::*;
(
  input  logic [1:0]      req_i,
  input  logic [ID_W-1:0] last_i,
  input  logic            lock_vld_i,
  input  logic [ID_W-1:0] lock_id_i,
  output logic            grant_o,
  output logic [ID_W-1:0] id_o
);

  logic [1:0] elig;

  always_comb begin
    elig = req_i;
    // a locked owner masks the other requester entirely
    if (lock_vld_i) begin
      elig = lock_id_i[0] ? (req_i & 2'b10) : (req_i & 2'b01);
    end
    grant_o = |elig;
    case (elig)
      2'b10:   id_o = ID_W'(1);
      2'b11:   id_o = ~last_i;
      default: id_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester IDLE/ACCESS/ACK memory port sequencer; MEMARB_LOCK_EN adds lock0/lock1
module mem_arbiter
  import memarb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
`ifdef MEMARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  input  logic              req0,
  input  logic              we0,
  input  logic              dbl0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic              dbl1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_dbl_rd,
  output logic              mem_dbl_wr,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state_q;
  mem_req_t          lat_q;
  mem_req_t          lat_d;
  logic [ID_W-1:0]   id_q;
  logic [ID_W-1:0]   last_q;
  logic [DATA_W-1:0] rdata_q;
  logic              grant;
  logic [ID_W-1:0]   pick_id;
  logic              lock_vld;
  logic [ID_W-1:0]   lock_id;
  logic              in_access;
  logic              in_ack;

`ifdef MEMARB_LOCK_EN
  logic            lock_vld_q;
  logic [ID_W-1:0] lock_id_q;
  logic            pick_lock;

  assign pick_lock = pick_id[0] ? lock1 : lock0;
  assign lock_vld  = lock_vld_q;
  assign lock_id   = lock_id_q;
`else
  assign lock_vld  = 1'b0;
  assign lock_id   = '0;
`endif

  rr_pick2 u_pick (
    .req_i      ({req1, req0}),
    .last_i     (last_q),
    .lock_vld_i (lock_vld),
    .lock_id_i  (lock_id),
    .grant_o    (grant),
    .id_o       (pick_id)
  );

  always_comb begin
    lat_d = '0;
    if (pick_id[0]) begin
      lat_d.we    = we1;
      lat_d.dbl   = dbl1;
      lat_d.addr  = addr1;
      lat_d.wdata = wdata1;
    end else begin
      lat_d.we    = we0;
      lat_d.dbl   = dbl0;
      lat_d.addr  = addr0;
      lat_d.wdata = wdata0;
    end
  end

  // last_q resets to 1 so requester 0 wins the first contention
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      id_q       <= '0;
      last_q     <= ID_W'(1);
      rdata_q    <= '0;
`ifdef MEMARB_LOCK_EN
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            lat_q      <= lat_d;
            id_q       <= pick_id;
            last_q     <= pick_id;
            state_q    <= ACCESS;
`ifdef MEMARB_LOCK_EN
            lock_vld_q <= pick_lock;
            lock_id_q  <= pick_id;
`endif
          end
        end
        ACCESS: begin
          rdata_q <= mem_rdata;
          state_q <= ACK;
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_access = (state_q == ACCESS);
  assign in_ack    = (state_q == ACK);

  // mem_we is gated by rst so a reset landing in ACCESS never commits the write
  assign mem_addr   = in_access ? lat_q.addr  : '0;
  assign mem_wdata  = in_access ? lat_q.wdata : '0;
  assign mem_we     = in_access & lat_q.we & ~rst;
  assign mem_dbl_rd = in_access & lat_q.dbl & ~lat_q.we;
  assign mem_dbl_wr = in_access & lat_q.dbl & lat_q.we;

  assign ack0   = in_ack & ~id_q[0];
  assign ack1   = in_ack & id_q[0];
  assign rdata0 = ack0 ? rdata_q : '0;
  assign rdata1 = ack1 ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with behavioural memory and arbitration model
module tb_mem_arbiter;

  typedef struct packed {
    logic        we;
    logic        dbl;
    logic [11:0] addr;
    logic [15:0] wdata;
  } op_t;

  typedef struct {
    int          id;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, dbl0, req1, we1, dbl1;
  logic [11:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_we, mem_dbl_rd, mem_dbl_wr;
`ifdef MEMARB_LOCK_EN
  logic        lock0, lock1;
`endif

  logic [15:0] tb_mem  [2048];
  logic [15:0] ref_mem [2048];
  logic        mem_clear;
  logic [15:0] mem_ptr;
  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  bit          last_m;

  mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
`ifdef MEMARB_LOCK_EN
    .lock0      (lock0),
    .lock1      (lock1),
`endif
    .req0       (req0),
    .we0        (we0),
    .dbl0       (dbl0),
    .addr0      (addr0),
    .wdata0     (wdata0),
    .ack0       (ack0),
    .rdata0     (rdata0),
    .req1       (req1),
    .we1        (we1),
    .dbl1       (dbl1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .ack1       (ack1),
    .rdata1     (rdata1),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_dbl_rd (mem_dbl_rd),
    .mem_dbl_wr (mem_dbl_wr),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // memory: word index addr[11:1], block b initialised to b<<12
  always_comb begin
    mem_ptr   = tb_mem[mem_addr[11:1]];
    mem_rdata = mem_dbl_rd ? tb_mem[mem_ptr[11:1]] : mem_ptr;
  end

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 2048; i++) tb_mem[i] <= 16'((i >> 9) << 12);
    end else if (mem_we) begin
      if (mem_dbl_wr) tb_mem[tb_mem[mem_addr[11:1]][11:1]] <= mem_wdata;
      else            tb_mem[mem_addr[11:1]] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_exec(input op_t o);
    logic [15:0] old;
    old = ref_mem[o.addr[11:1]];
    if (o.we) begin
      if (o.dbl) ref_mem[old[11:1]] = o.wdata;
      else       ref_mem[o.addr[11:1]] = o.wdata;
      return old;
    end
    return o.dbl ? ref_mem[old[11:1]] : old;
  endfunction

  task automatic push(input int id, input op_t o, input int c);
    exp_t e;
    e.id    = id;
    e.rdata = ref_exec(o);
    e.cyc   = c;
    sb.push_back(e);
  endtask

  function automatic op_t mk(input bit we, input bit dbl, input logic [11:0] a, input logic [15:0] d);
    op_t o;
    o.we = we; o.dbl = dbl; o.addr = a; o.wdata = d;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.we    = 1'($urandom_range(0, 1));
    o.dbl   = ($urandom_range(0, 3) == 0);
    o.addr  = 12'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 1) | $urandom_range(0, 1));
    o.wdata = 16'($urandom);
    return o;
  endfunction

  always @(negedge clk) begin
    if (!rst && (ack0 || ack1)) begin
      if (ack0 && ack1) chk("ack_both", 1, 0);
      else if (sb.size() == 0) chk("unexpected_ack", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("ack_id", ack1, mon_e.id);
        chk("rdata", ack1 ? rdata1 : rdata0, mon_e.rdata);
        chk("ack_cycle", cyc, mon_e.cyc);
        chk("other_rdata_zero", ack1 ? rdata0 : rdata1, 0);
      end
    end
  end

  task automatic drive0(input op_t o);
    we0 = o.we; dbl0 = o.dbl; addr0 = o.addr; wdata0 = o.wdata;
  endtask

  task automatic drive1(input op_t o);
    we1 = o.we; dbl1 = o.dbl; addr1 = o.addr; wdata1 = o.wdata;
  endtask

  // model: single requester wins; with both, the one not granted last goes first
  task automatic run_round(input bit en0, input op_t o0, input bit en1, input op_t o1);
    int c0;
    bit first, got0, got1;
    @(posedge clk); #1;
    c0 = cyc;
    if (en0 && en1) begin
      first = !last_m;
      push(first, first ? o1 : o0, c0 + 2);
      push(!first, first ? o0 : o1, c0 + 5);
      last_m = !first;
    end else if (en0) begin
      push(0, o0, c0 + 2);
      last_m = 1'b0;
    end else if (en1) begin
      push(1, o1, c0 + 2);
      last_m = 1'b1;
    end
    drive0(o0); drive1(o1);
    req0 = en0; req1 = en1;
    got0 = !en0; got1 = !en1;
    for (int k = 0; k < 20 && !(got0 && got1); k++) begin
      @(negedge clk);
      if (ack0) got0 = 1'b1;
      if (ack1) got1 = 1'b1;
      @(posedge clk); #1;
      if (got0) req0 = 1'b0;
      if (got1) req1 = 1'b0;
    end
    if (!(got0 && got1)) begin
      chk("ack_timeout", {30'b0, got1, got0}, 3);
      req0 = 1'b0; req1 = 1'b0;
    end
  endtask

  task automatic wait_ack(input bit id);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = id ? ack1 : ack0;
      @(posedge clk); #1;
    end
    if (!got) chk(id ? "ack1_timeout" : "ack0_timeout", 0, 1);
  endtask

  task automatic run_chain(input op_t a, input op_t b);
    int c0;
    @(posedge clk); #1;
    c0 = cyc;
    push(0, a, c0 + 2);
    push(0, b, c0 + 5);
    last_m = 1'b0;
    drive0(a); req0 = 1'b1;
    wait_ack(0);
    drive0(b);
    wait_ack(0);
    req0 = 1'b0;
  endtask

  task automatic run_reset_write();
    @(posedge clk); #1;
    drive0(mk(1, 0, 12'h406, 16'h1234));
    req0 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    chk("rst_access_mem_we", mem_we, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_m = 1'b1;
    @(negedge clk);
    chk("rst_access_no_ack", ack0, 0);
    chk("rst_access_idle_addr", mem_addr, 0);
    run_round(1, mk(0, 0, 12'h406, 0), 0, mk(0, 0, 0, 0));
  endtask

`ifdef MEMARB_LOCK_EN
  task automatic run_lock();
    int c0;
    op_t oa, ob, oc;
    oa = mk(0, 0, 12'h410, 0);
    ob = mk(1, 0, 12'h410, 16'hBEEF);
    oc = mk(0, 0, 12'h410, 0);
    @(posedge clk); #1;
    c0 = cyc;
    push(1, oa, c0 + 2);
    push(1, ob, c0 + 5);
    push(0, oc, c0 + 8);
    last_m = 1'b0;
    drive1(oa); lock1 = 1'b1; req1 = 1'b1;
    @(posedge clk); #1;
    drive0(oc); lock0 = 1'b0; req0 = 1'b1;
    wait_ack(1);
    drive1(ob); lock1 = 1'b0;
    wait_ack(1);
    req1 = 1'b0;
    wait_ack(0);
    req0 = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; mem_clear = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    drive0(mk(0, 0, 0, 0)); drive1(mk(0, 0, 0, 0));
`ifdef MEMARB_LOCK_EN
    lock0 = 1'b0; lock1 = 1'b0;
`endif
    for (int i = 0; i < 2048; i++) ref_mem[i] = 16'((i >> 9) << 12);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ack0", ack0, 0);
    chk("reset_ack1", ack1, 0);
    chk("reset_rdata0", rdata0, 0);
    chk("reset_rdata1", rdata1, 0);
    chk("reset_mem_we", mem_we, 0);
    chk("reset_mem_addr", mem_addr, 0);
    mem_clear = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_m = 1'b1;

    run_round(1, mk(0, 0, 12'h402, 0), 1, mk(0, 0, 12'h802, 0));
    run_round(0, mk(0, 0, 0, 0), 1, mk(0, 0, 12'h000, 0));
    run_round(1, mk(0, 0, 12'hC00, 0), 1, mk(0, 0, 12'h400, 0));
    run_round(1, mk(0, 0, 12'h002, 0), 1, mk(0, 0, 12'h004, 0));

    run_round(1, mk(1, 0, 12'h402, 16'hABCD), 0, mk(0, 0, 0, 0));
    run_round(1, mk(0, 0, 12'h402, 0), 0, mk(0, 0, 0, 0));

    run_round(1, mk(1, 0, 12'h404, 16'h0802), 0, mk(0, 0, 0, 0));
    run_round(0, mk(0, 0, 0, 0), 1, mk(0, 1, 12'h404, 0));
    run_round(1, mk(1, 1, 12'h404, 16'h5555), 0, mk(0, 0, 0, 0));
    run_round(0, mk(0, 0, 0, 0), 1, mk(0, 0, 12'h802, 0));

    run_chain(mk(1, 0, 12'h408, 16'h7777), mk(0, 0, 12'h408, 0));

    run_reset_write();

    for (int r = 0; r < 40; r++) begin
      int m;
      m = $urandom_range(1, 3);
      run_round(m[0], rand_op(), m[1], rand_op());
    end

`ifdef MEMARB_LOCK_EN
    run_lock();
`endif

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
